// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle MIPS controller and its datapath.
// The master modport is the controller; the slave modport is the datapath.
interface multicycle_controller_if;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        pc_en;
    logic        iord;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        reg_write;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [2:0]  alucontrol;
    logic [1:0]  pc_src;
    logic        illegal_op;
    logic [3:0]  state;

    modport master (
        input  instr, zero, mem_ready,
        output pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alucontrol, pc_src, illegal_op, state
    );

    modport slave (
        output instr, zero, mem_ready,
        input  pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
               reg_write, alu_src_a, alu_src_b, alucontrol, pc_src, illegal_op, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// Sequencing FSM for a multicycle MIPS datapath (lw, sw, R-type, beq, addi, j)
// with memory-ready stalls in FETCH, MEMRD and MEMWR.
module multicycle_controller #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic                     clk,
    input  logic                     rst_n,
    multicycle_controller_if.master  bus
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
        BEQ    = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t     cur;
    logic       is_store;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       funct_ok;
    logic [2:0] funct_alu;

    assign opcode = bus.instr[31:26];
    assign funct  = bus.instr[5:0];

    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (funct)
            6'b100000: funct_alu = ALU_ADD;
            6'b100010: funct_alu = ALU_SUB;
            6'b100100: funct_alu = ALU_AND;
            6'b100101: funct_alu = ALU_OR;
            6'b101010: funct_alu = ALU_SLT;
            default:   funct_ok  = 1'b0;
        endcase
    end

    // is_store remembers lw vs sw at DECODE so MEMADR need not look at instr again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur      <= FETCH;
            is_store <= 1'b0;
        end else begin
            case (cur)
                FETCH:  if (bus.mem_ready) cur <= DECODE;
                DECODE: begin
                    is_store <= (opcode == OP_SW);
                    case (opcode)
                        OP_LW, OP_SW: cur <= MEMADR;
                        OP_RTYPE:     cur <= EXEC;
                        OP_BEQ:       cur <= BEQ;
                        OP_ADDI:      cur <= ADDIEX;
                        OP_J:         cur <= JUMP;
                        default:      cur <= FETCH;
                    endcase
                end
                MEMADR: cur <= is_store ? MEMWR : MEMRD;
                MEMRD:  if (bus.mem_ready) cur <= MEMWB;
                MEMWR:  if (bus.mem_ready) cur <= FETCH;
                EXEC:   cur <= funct_ok ? ALUWB : FETCH;
                ADDIEX: cur <= ADDIWB;
                default: cur <= FETCH;
            endcase
        end
    end

    logic       pc_en_d, mem_read_d, mem_write_d, ir_write_d, reg_write_d, illegal_d;
    logic       iord_d, reg_dst_d, mem_to_reg_d, alu_src_a_d;
    logic [1:0] alu_src_b_d, pc_src_d;
    logic [2:0] alucontrol_d;

    always_comb begin
        pc_en_d      = 1'b0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        ir_write_d   = 1'b0;
        reg_write_d  = 1'b0;
        illegal_d    = 1'b0;
        iord_d       = 1'b0;
        reg_dst_d    = 1'b0;
        mem_to_reg_d = 1'b0;
        alu_src_a_d  = 1'b0;
        alu_src_b_d  = 2'b00;
        pc_src_d     = 2'b00;
        alucontrol_d = 3'b000;
        case (cur)
            FETCH: begin
                mem_read_d   = 1'b1;
                alu_src_b_d  = 2'b01;
                alucontrol_d = ALU_ADD;
                ir_write_d   = bus.mem_ready;
                pc_en_d      = bus.mem_ready;
            end
            DECODE: begin
                alu_src_b_d  = 2'b11;
                alucontrol_d = ALU_ADD;
                illegal_d    = !(opcode == OP_LW || opcode == OP_SW || opcode == OP_RTYPE ||
                                 opcode == OP_BEQ || opcode == OP_ADDI || opcode == OP_J);
            end
            MEMADR, ADDIEX: begin
                alu_src_a_d  = 1'b1;
                alu_src_b_d  = 2'b10;
                alucontrol_d = ALU_ADD;
            end
            MEMRD: begin
                iord_d     = 1'b1;
                mem_read_d = 1'b1;
            end
            MEMWB: begin
                mem_to_reg_d = 1'b1;
                reg_write_d  = 1'b1;
            end
            MEMWR: begin
                iord_d      = 1'b1;
                mem_write_d = 1'b1;
            end
            EXEC: begin
                alu_src_a_d  = 1'b1;
                alucontrol_d = funct_alu;
                illegal_d    = !funct_ok;
            end
            ALUWB: begin
                reg_dst_d   = 1'b1;
                reg_write_d = 1'b1;
            end
            BEQ: begin
                alu_src_a_d  = 1'b1;
                alucontrol_d = ALU_SUB;
                pc_src_d     = 2'b01;
                pc_en_d      = bus.zero;
            end
            ADDIWB: reg_write_d = 1'b1;
            JUMP: begin
                pc_src_d = 2'b10;
                pc_en_d  = 1'b1;
            end
            default: ;
        endcase
    end

    // Enables are gated by rst_n so nothing writes while reset is held.
    assign bus.pc_en      = pc_en_d     & rst_n;
    assign bus.mem_read   = mem_read_d  & rst_n;
    assign bus.mem_write  = mem_write_d & rst_n;
    assign bus.ir_write   = ir_write_d  & rst_n;
    assign bus.reg_write  = reg_write_d & rst_n;
    assign bus.illegal_op = illegal_d   & rst_n;
    assign bus.iord       = iord_d;
    assign bus.reg_dst    = reg_dst_d;
    assign bus.mem_to_reg = mem_to_reg_d;
    assign bus.alu_src_a  = alu_src_a_d;
    assign bus.alu_src_b  = alu_src_b_d;
    assign bus.pc_src     = pc_src_d;
    assign bus.alucontrol = alucontrol_d;
    assign bus.state      = cur;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench for multicycle_controller: an instruction-level
// model predicts the per-cycle state trace and control outputs.
module tb_multicycle_controller;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          st_q[$];
    logic        mr_q[$];
    logic [20:0] obs_q[$];
    logic [20:0] exp_q[$];

    function automatic logic legal_opcode(input logic [5:0] op);
        return op == 6'h00 || op == 6'h23 || op == 6'h2b || op == 6'h04 ||
               op == 6'h08 || op == 6'h02;
    endfunction

    function automatic logic [20:0] actual_vec();
        return {bus.state, bus.pc_en, bus.iord, bus.mem_read, bus.mem_write, bus.ir_write,
                bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
                bus.alucontrol, bus.pc_src, bus.illegal_op};
    endfunction

    // Expected outputs of each phase of an instruction, straight from the control table.
    function automatic logic [20:0] expect_vec(input int st, input logic [31:0] ins,
                                               input logic z, input logic mr);
        logic pe, io, mrd, mwr, irw, rd, m2r, rw, sa, il;
        logic [1:0] sb, ps;
        logic [2:0] ac;
        {pe, io, mrd, mwr, irw, rd, m2r, rw, sa, il} = '0;
        sb = 2'b00; ps = 2'b00; ac = 3'b000;
        case (st)
            0:  begin mrd = 1; sb = 2'b01; ac = 3'b010; irw = mr; pe = mr; end
            1:  begin sb = 2'b11; ac = 3'b010; il = !legal_opcode(ins[31:26]); end
            2:  begin sa = 1; sb = 2'b10; ac = 3'b010; end
            3:  begin io = 1; mrd = 1; end
            4:  begin m2r = 1; rw = 1; end
            5:  begin io = 1; mwr = 1; end
            6:  begin
                    sa = 1;
                    case (ins[5:0])
                        6'h20: ac = 3'b010;
                        6'h22: ac = 3'b110;
                        6'h24: ac = 3'b000;
                        6'h25: ac = 3'b001;
                        6'h2a: ac = 3'b111;
                        default: begin ac = 3'b010; il = 1; end
                    endcase
                end
            7:  begin rd = 1; rw = 1; end
            8:  begin sa = 1; ac = 3'b110; ps = 2'b01; pe = z; end
            9:  begin sa = 1; sb = 2'b10; ac = 3'b010; end
            10: rw = 1;
            11: begin ps = 2'b10; pe = 1; end
            default: ;
        endcase
        return {4'(st), pe, io, mrd, mwr, irw, rd, m2r, rw, sa, sb, ac, ps, il};
    endfunction

    function automatic logic funct_valid(input logic [5:0] f);
        return f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 || f == 6'h2a;
    endfunction

    // Drives one instruction from FETCH to its last phase; fw/mw are wait cycles
    // inserted in FETCH and in the data memory access. Records expected/observed vectors.
    task automatic applyStimulus(input logic [31:0] ins, input logic z, input int fw, input int mw);
        st_q.delete(); mr_q.delete(); obs_q.delete(); exp_q.delete();
        for (int i = 0; i < fw; i++) begin st_q.push_back(0); mr_q.push_back(1'b0); end
        st_q.push_back(0); mr_q.push_back(1'b1);
        st_q.push_back(1); mr_q.push_back(1'($urandom_range(0, 1)));
        case (ins[31:26])
            6'h23: begin
                st_q.push_back(2); mr_q.push_back(1'($urandom_range(0, 1)));
                for (int i = 0; i < mw; i++) begin st_q.push_back(3); mr_q.push_back(1'b0); end
                st_q.push_back(3); mr_q.push_back(1'b1);
                st_q.push_back(4); mr_q.push_back(1'($urandom_range(0, 1)));
            end
            6'h2b: begin
                st_q.push_back(2); mr_q.push_back(1'($urandom_range(0, 1)));
                for (int i = 0; i < mw; i++) begin st_q.push_back(5); mr_q.push_back(1'b0); end
                st_q.push_back(5); mr_q.push_back(1'b1);
            end
            6'h00: begin
                st_q.push_back(6); mr_q.push_back(1'($urandom_range(0, 1)));
                if (funct_valid(ins[5:0])) begin
                    st_q.push_back(7); mr_q.push_back(1'($urandom_range(0, 1)));
                end
            end
            6'h04: begin st_q.push_back(8); mr_q.push_back(1'($urandom_range(0, 1))); end
            6'h08: begin
                st_q.push_back(9);  mr_q.push_back(1'($urandom_range(0, 1)));
                st_q.push_back(10); mr_q.push_back(1'($urandom_range(0, 1)));
            end
            6'h02: begin st_q.push_back(11); mr_q.push_back(1'($urandom_range(0, 1))); end
            default: ;
        endcase
        bus.instr = ins;
        bus.zero  = z;
        for (int i = 0; i < st_q.size(); i++) begin
            bus.mem_ready = mr_q[i];
            @(negedge clk);
            obs_q.push_back(actual_vec());
            exp_q.push_back(expect_vec(st_q[i], ins, z, mr_q[i]));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string name);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("[TB] FAIL %s cycle %0d: got %h expected %h", name, i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset();
        logic [20:0] e;
        rst_n = 1'b0;
        bus.instr = 32'hAC820008;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        e = {4'd0, 5'b0, 4'b0, 2'b01, 3'b010, 2'b00, 1'b0};
        checks++;
        if (actual_vec() !== e) begin
            failures++;
            $display("[TB] FAIL reset_hold: got %h expected %h", actual_vec(), e);
        end
        rst_n = 1'b1;
        bus.mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.state !== 4'd5 || bus.mem_write !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reach_memwr: state %0d mem_write %b expected 5/1", bus.state, bus.mem_write);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.state !== 4'd0 || bus.mem_write !== 1'b0 || bus.mem_read !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_async: state %0d mem_write %b mem_read %b expected 0/0/0",
                     bus.state, bus.mem_write, bus.mem_read);
        end
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.state, bus.mem_read, bus.ir_write, bus.pc_en} !== {4'd0, 3'b111}) begin
            failures++;
            $display("[TB] FAIL reset_release: state %0d rd/irw/pc %b%b%b expected 0 111",
                     bus.state, bus.mem_read, bus.ir_write, bus.pc_en);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.state !== 4'd1) begin
            failures++;
            $display("[TB] FAIL reset_to_decode: state %0d expected 1", bus.state);
        end
        rst_n = 1'b0;
        bus.mem_ready = 1'b0;
        #1 rst_n = 1'b1;
    endtask

    task automatic test_lw();
        applyStimulus(32'h8C820004, 1'b0, 0, 0);
        checkOutput("lw");
    endtask

    task automatic test_sw_wait();
        applyStimulus(32'hAC820008, 1'b1, 0, 3);
        checkOutput("sw_wait");
    endtask

    task automatic test_rtype();
        applyStimulus(32'h00432022, 1'b0, 1, 0);
        checkOutput("rtype_sub");
        applyStimulus(32'h0043202A, 1'b1, 0, 0);
        checkOutput("rtype_slt");
        applyStimulus(32'h00432000, 1'b0, 0, 0);
        checkOutput("rtype_bad_funct");
    endtask

    task automatic test_beq();
        applyStimulus(32'h10430003, 1'b1, 0, 0);
        checkOutput("beq_taken");
        applyStimulus(32'h10430003, 1'b0, 0, 0);
        checkOutput("beq_not_taken");
    endtask

    task automatic test_jump_illegal();
        applyStimulus(32'h08000040, 1'b0, 0, 0);
        checkOutput("jump");
        applyStimulus(32'hFC000000, 1'b0, 2, 0);
        checkOutput("illegal_opcode");
    endtask

    task automatic test_back_to_back();
        logic [5:0]  ops[7];
        logic [5:0]  fns[6];
        logic [31:0] ins;
        ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h02, 6'h3f};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h01};
        for (int n = 0; n < 40; n++) begin
            ins = $urandom;
            ins[31:26] = ops[$urandom_range(0, 6)];
            if (ins[31:26] == 6'h3f) ins[31:26] = 6'($urandom_range(0, 63));
            if (ins[31:26] == 6'h00) ins[5:0] = fns[$urandom_range(0, 5)];
            applyStimulus(ins, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3));
            checkOutput("random");
        end
        @(negedge clk);
        checks++;
        if (bus.state !== 4'd0) begin
            failures++;
            $display("[TB] FAIL final_fetch: state %0d expected 0", bus.state);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_lw();
        test_sw_wait();
        test_rtype();
        test_beq();
        test_jump_illegal();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Sequencing FSM for the multicycle MIPS datapath: a single shared memory, ALU and register file.
- Decodes the instruction held in the datapath's instruction register.
- Drives all mux selects, enables and ALU control per cycle, for lw, sw, R-type (add/sub/and/or/slt), beq, addi and j.
- Stalls on a memory-ready handshake, so one datapath serves variable-latency memory.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word opcode
- OP_SW, 6'b101011, store word opcode
- OP_BEQ, 6'b000100, branch-equal opcode
- OP_ADDI, 6'b001000, add-immediate opcode
- OP_J, 6'b000010, jump opcode

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- instr  input  32  IR contents; opcode [31:26], funct [5:0]
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes the current access this cycle
- pc_en  output  1  PC register load enable
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- ir_write  output  1  IR load enable
- reg_dst  output  1  write register select: 0 = rt, 1 = rd
- mem_to_reg  output  1  write data select: 0 = ALUOut, 1 = MDR
- reg_write  output  1  register file write enable
- alu_src_a  output  1  ALU A select: 0 = PC, 1 = regA
- alu_src_b  output  2  ALU B select: 00 = regB, 01 = 4, 10 = sign-extended imm, 11 = imm<<2
- alucontrol  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- pc_src  output  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- illegal_op  output  1  one-cycle pulse on unsupported opcode or funct
- state  output  4  current state, for debug and verification

Behaviour:
- States (encoding 0-11):
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXEC=6, ALUWB=7, BEQ=8, ADDIEX=9, ADDIWB=10, JUMP=11
- Reset: async, rst_n low forces state=FETCH immediately.
  - While rst_n is low, pc_en, mem_read, mem_write, ir_write, reg_write and illegal_op are forced to 0.
  - Select outputs take their FETCH values.
  - Reset asserted mid-instruction abandons it; no partial write occurs after rst_n falls.
- Outputs are Moore-decoded from state. Exceptions: pc_en, ir_write and the mem_ready qualification below. Unlisted enables are 0; unlisted selects are 0.
- FETCH:
  - Outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alucontrol=add, pc_src=00.
  - ir_write=pc_en=mem_ready.
  - Stay while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alucontrol=add (branch target into ALUOut).
  - Next state by opcode: lw/sw -> MEMADR, R-type -> EXEC, beq -> BEQ, addi -> ADDIEX, j -> JUMP.
  - Any other opcode -> FETCH with illegal_op=1 for this cycle.
- MEMADR: alu_src_a=1, alu_src_b=10, add. Next: lw -> MEMRD, sw -> MEMWR.
- MEMRD: iord=1, mem_read=1. Stay until mem_ready, then -> MEMWB.
- MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. Next: FETCH.
- MEMWR:
  - Outputs: iord=1, mem_write=1.
  - mem_write holds until the mem_ready cycle inclusive.
  - Stay until mem_ready, then -> FETCH.
- EXEC:
  - Outputs: alu_src_a=1, alu_src_b=00.
  - alucontrol by funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - Next: ALUWB.
  - Unknown funct: alucontrol=add, illegal_op=1, next FETCH (no writeback).
- ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1. Next: FETCH.
- BEQ:
  - Outputs: alu_src_a=1, alu_src_b=00, alucontrol=sub, pc_src=01.
  - pc_en = zero, evaluated in this cycle.
  - Next: FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, add. Next: ADDIWB.
- ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1. Next: FETCH.
- JUMP: pc_src=10, pc_en=1. Next: FETCH.
- mem_read and mem_write are never asserted together.
- reg_write is asserted only in writeback states.
- Instruction latency assuming mem_ready always 1 (FETCH to next FETCH):
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.
  - Each wait cycle in FETCH, MEMRD or MEMWR adds 1.
- Unreachable state codes 12-15 -> FETCH on the next clock, all enables 0.
- zero is ignored outside BEQ.
- instr is sampled combinationally, only in DECODE and EXEC.

Test Plan:
- Reset: rst_n low mid-MEMWR -> state=0 immediately, mem_write=0. Release with mem_ready=1 -> FETCH with mem_read=1, ir_write=1, pc_en=1.
- lw 0x8C820004, mem_ready tied 1 -> states 0,1,2,3,4,0. reg_write=1 only in state 4, with mem_to_reg=1, reg_dst=0.
- sw with mem_ready low 3 cycles in MEMWR -> state 5 held 4 cycles, mem_write=1 each cycle, then FETCH. No reg_write seen.
- R-type sub (funct 100010) -> EXEC alucontrol=110, ALUWB reg_dst=1. Repeat with slt -> 111; funct 000000 -> illegal_op pulse, then FETCH.
- beq with zero=1 -> pc_en=1, pc_src=01 in state 8. With zero=0 -> pc_en=0; both return to FETCH after 3 total cycles.
- j -> state 11, pc_src=10, pc_en=1. Opcode 6'b111111 -> illegal_op pulse in DECODE, next FETCH, no writes.
